traffic_intersection_ctrl: RTL and testbench
============================================

# traffic_intersection_ctrl

Parametrised two-road intersection controller: next generation of the fixed-timing major/minor controller. It adds:
- configurable phase durations;
- minor-road green extension with a hard maximum;
- a latched pedestrian request with a walk output;
- a flashing (night/fault) mode entered and left only through all-red.

Phase timing is counted in clock cycles; any prescaling happens upstream.

## Interface
Parameters:
- CNT_W, 8, phase timer width.
- MAJOR_MIN_GREEN, 8, minimum major green cycles.
- MINOR_MIN_GREEN, 4, minimum minor green cycles.
- MINOR_MAX_GREEN, 10, maximum minor green cycles. Must be ≥ MINOR_MIN_GREEN.
- YELLOW_TIME, 3, yellow cycles per road.
- ALL_RED_TIME, 2, all-red clearance cycles.
- FLASH_HALF, 4, cycles per flash half-period.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sensor  in  1  minor-road vehicle present; synchronous and level-sensitive.
- ped_req  in  1  pedestrian button; a one-cycle pulse is enough.
- flash_mode  in  1  request for flashing mode; level-sensitive.
- major  out  3  major lights {red,yellow,green}.
- minor  out  3  minor lights {red,yellow,green}.
- ped_walk  out  1  walk signal for the minor crossing.

## Operation
- Light encoding: RED=3'b100, YELLOW=3'b010, GREEN=3'b001, OFF=3'b000.
- States: MAJ_GREEN, MAJ_YELLOW, ALL_RED_1, MIN_GREEN, MIN_YELLOW, ALL_RED_2, FLASH.
- Phase timer: counts up from 0 each cycle in a state. It clears to 0 on every state change and saturates at all-ones.
- ped_pending:
  - set by ped_req in any state except MIN_GREEN;
  - cleared on entry to MIN_GREEN;
  - a ped_req during MIN_GREEN is ignored.

Transitions (t = timer):
- MAJ_GREEN → MAJ_YELLOW when either:
  - t ≥ MAJOR_MIN_GREEN-1 and (sensor or ped_pending); or
  - flash_mode, immediately, with no minimum.
- MAJ_YELLOW → ALL_RED_1 at t = YELLOW_TIME-1.
- ALL_RED_1 → at t = ALL_RED_TIME-1, goes to FLASH if flash_mode, else to MIN_GREEN.
- MIN_GREEN → MIN_YELLOW when any of:
  - t ≥ MINOR_MIN_GREEN-1 and !sensor;
  - t = MINOR_MAX_GREEN-1;
  - flash_mode.
- MIN_YELLOW → ALL_RED_2 at t = YELLOW_TIME-1.
- ALL_RED_2 → at t = ALL_RED_TIME-1, goes to FLASH if flash_mode, else to MAJ_GREEN.
- FLASH → ALL_RED_2 when flash_mode = 0, with the timer cleared.

Outputs (Moore, decoded from registered state):
- MAJ_GREEN: major GREEN, minor RED.
- MAJ_YELLOW: major YELLOW, minor RED.
- ALL_RED_x: both RED.
- MIN_GREEN: major RED, minor GREEN. ped_walk = 1 only if ped_pending was set at entry (walk_flag, registered on entry).
- MIN_YELLOW: major RED, minor YELLOW.
- FLASH:
  - phase bit toggles every FLASH_HALF cycles; phase = 0 on FLASH entry;
  - phase 0: major YELLOW, minor RED;
  - phase 1: both OFF.
- ped_walk = 0 in every state other than MIN_GREEN.

Boundary rules:
- A green state never transitions directly to the other road's green.
- A green state never enters FLASH without passing through yellow and then all-red.
- Sensor held high continuously: MIN_GREEN lasts exactly MINOR_MAX_GREEN cycles, then the cycle repeats with MAJ_GREEN for the full MAJOR_MIN_GREEN.
- Sensor and flash_mode both high in MAJ_GREEN: flash_mode wins; the path continues through ALL_RED_1 to FLASH.
- flash_mode dropping during MAJ_YELLOW or ALL_RED_x: no effect until the exit decision; the state then follows the normal path.

## Timing
- Reset (asynchronous, reset = 0):
  - state = MAJ_GREEN, timer = 0, ped_pending = 0, walk_flag = 0, flash phase = 0;
  - major = GREEN, minor = RED, ped_walk = 0, all immediately.
- Inputs are sampled on the rising edge. Outputs change on the same edge as the state register, so the response is one cycle after the deciding input.
- Reset asserted mid-phase aborts to the reset state with no yellow.
- Phase lengths with defaults:
  - major green ≥ 8 cycles;
  - yellow = 3;
  - all-red = 2;
  - minor green 4–10.
- Parameter-legal range: every duration is in the range 1 to 2^CNT_W-1.

## Structure
- Package traffic_pkg holds:
  - the state enum;
  - the light encoding constants RED/YELLOW/GREEN/OFF;
  - the light-pair output struct.
- One sub-module, phase_timer: a CNT_W up-counter with synchronous clear and saturation, instantiated once.
- FSM, pedestrian latch and flash-phase logic live in the top module.

## Test plan
- Reset released, sensor = 0, ped_req = 0, for 50 cycles → major = 3'b001 and minor = 3'b100 throughout.
- sensor = 1 from reset release and held → major changes as follows:
  - GREEN for 8 cycles;
  - YELLOW at cycle 8;
  - RED at cycle 11;
  - minor GREEN at cycle 13, lasting exactly 10 cycles;
  - minor YELLOW, then all-red, then major GREEN.
- sensor pulsed for 2 cycles at cycle 10 → minor green lasts exactly 4 cycles.
- ped_req pulse at cycle 3, sensor = 0 → minor GREEN at cycle 13 with ped_walk = 1 for its 4 cycles. A second ped_req during MIN_GREEN yields no second walk.
- flash_mode = 1 at cycle 2 in MAJ_GREEN → the following sequence occurs:
  - YELLOW for 3 cycles;
  - all-red for 2 cycles;
  - FLASH, alternating 4 cycles major YELLOW/minor RED and 4 cycles both OFF;
  - after flash_mode drops: 2 cycles all-red, then MAJ_GREEN.
- reset asserted mid MIN_YELLOW → outputs are at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the two-road intersection controller: FSM states, light
// encodings and the decoded light pair.
package traffic_pkg;

    typedef enum logic [2:0] {
        StMajGreen,
        StMajYellow,
        StAllRed1,
        StMinGreen,
        StMinYellow,
        StAllRed2,
        StFlash
    } state_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    typedef struct packed {
        logic [2:0] major;
        logic [2:0] minor;
    } lights_t;

    // Light pair shown in a given state; phase only matters while flashing.
    function automatic lights_t decode_lights(input state_e st, input logic phase);
        lights_t l;
        l.major = RED;
        l.minor = RED;
        case (st)
            StMajGreen:  l.major = GREEN;
            StMajYellow: l.major = YELLOW;
            StMinGreen:  l.minor = GREEN;
            StMinYellow: l.minor = YELLOW;
            StFlash: begin
                if (phase) begin
                    l.major = OFF;
                    l.minor = OFF;
                end else begin
                    l.major = YELLOW;
                end
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: up-counter with synchronous clear that saturates at all-ones.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != {CNT_W{1'b1}}) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with minor-road extension, pedestrian walk
// latch and a flashing mode reached only through yellow and all-red.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned MAJOR_MIN_GREEN = 8,
    parameter int unsigned MINOR_MIN_GREEN = 4,
    parameter int unsigned MINOR_MAX_GREEN = 10,
    parameter int unsigned YELLOW_TIME     = 3,
    parameter int unsigned ALL_RED_TIME    = 2,
    parameter int unsigned FLASH_HALF      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] major,
    output logic [2:0] minor,
    output logic       ped_walk
);

    localparam logic [CNT_W-1:0] MajMinLast = CNT_W'(MAJOR_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MinMinLast = CNT_W'(MINOR_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MinMaxLast = CNT_W'(MINOR_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] FlashLast  = CNT_W'(FLASH_HALF - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] t;
    logic             state_change;
    logic             ped_pending_q, ped_pending_d;
    logic             walk_flag_q, walk_flag_d;
    logic             flash_phase_q, flash_phase_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    lights_t          lights_d;

    assign state_change = (state_d != state_q);

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .clock(clock),
        .reset(reset),
        .clear(state_change),
        .count(t)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StMajGreen: begin
                if (flash_mode || (t >= MajMinLast && (sensor || ped_pending_q))) begin
                    state_d = StMajYellow;
                end
            end
            StMajYellow: begin
                if (t == YellowLast) state_d = StAllRed1;
            end
            StAllRed1: begin
                if (t == AllRedLast) state_d = flash_mode ? StFlash : StMinGreen;
            end
            StMinGreen: begin
                if (flash_mode || (t >= MinMinLast && !sensor) || t == MinMaxLast) begin
                    state_d = StMinYellow;
                end
            end
            StMinYellow: begin
                if (t == YellowLast) state_d = StAllRed2;
            end
            StAllRed2: begin
                if (t == AllRedLast) state_d = flash_mode ? StFlash : StMajGreen;
            end
            StFlash: begin
                if (!flash_mode) state_d = StAllRed2;
            end
            default: state_d = StMajGreen;
        endcase
    end

    // Pedestrian latch: requests during minor green are dropped, and the walk
    // decision is frozen at minor-green entry.
    always_comb begin
        ped_pending_d = ped_pending_q;
        walk_flag_d   = 1'b0;
        if (state_q == StMinGreen) begin
            walk_flag_d = (state_d == StMinGreen) ? walk_flag_q : 1'b0;
        end else if (state_d == StMinGreen) begin
            walk_flag_d   = ped_pending_q | ped_req;
            ped_pending_d = 1'b0;
        end else begin
            ped_pending_d = ped_pending_q | ped_req;
        end
    end

    // Flash phase restarts at 0 on every FLASH entry.
    always_comb begin
        flash_cnt_d   = '0;
        flash_phase_d = 1'b0;
        if (state_q == StFlash && state_d == StFlash) begin
            if (flash_cnt_q == FlashLast) begin
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d   = flash_cnt_q + CNT_W'(1);
                flash_phase_d = flash_phase_q;
            end
        end
    end

    assign lights_d = decode_lights(state_d, flash_phase_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StMajGreen;
            ped_pending_q <= 1'b0;
            walk_flag_q   <= 1'b0;
            flash_phase_q <= 1'b0;
            flash_cnt_q   <= '0;
            major         <= GREEN;
            minor         <= RED;
            ped_walk      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            walk_flag_q   <= walk_flag_d;
            flash_phase_q <= flash_phase_d;
            flash_cnt_q   <= flash_cnt_d;
            major         <= lights_d.major;
            minor         <= lights_d.minor;
            ped_walk      <= walk_flag_d;
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench: each test queues per-cycle expected lights, a monitor pops
// and compares one entry every falling clock edge.
module tb_traffic_intersection_ctrl;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LO = 3'b000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic [2:0] major, minor;
    logic       ped_walk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        int         cyc;
        logic [2:0] maj;
        logic [2:0] mn;
        logic       w;
    } exp_t;

    exp_t  exp_q[$];
    int    push_cyc;
    string cur_tag;

    traffic_intersection_ctrl dut (
        .clock(clock),
        .reset(reset),
        .sensor(sensor),
        .ped_req(ped_req),
        .flash_mode(flash_mode),
        .major(major),
        .minor(minor),
        .ped_walk(ped_walk)
    );

    always #5 clock = ~clock;

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (major !== e.maj || minor !== e.mn || ped_walk !== e.w) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got major=%b minor=%b walk=%b, want major=%b minor=%b walk=%b",
                             e.tag, e.cyc, major, minor, ped_walk, e.maj, e.mn, e.w);
                end
            end
        end
    end

    task automatic push(input int n, input logic [2:0] maj, input logic [2:0] mn, input logic w);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = cur_tag;
            e.cyc = push_cyc;
            e.maj = maj;
            e.mn  = mn;
            e.w   = w;
            exp_q.push_back(e);
            push_cyc++;
        end
    endtask

    // Returns at a falling edge with reset just released: that interval is cycle 0.
    task automatic start_test(input string tag);
        reset      = 1'b0;
        sensor     = 1'b0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        repeat (3) @(negedge clock);
        reset    = 1'b1;
        cur_tag  = tag;
        push_cyc = 0;
    endtask

    // Drives cycles 0..n-1; ends at the falling edge of cycle n.
    task automatic run(input int n, input int s_lo, input int s_hi, input int p0, input int p1,
                       input int f_lo, input int f_hi);
        for (int k = 0; k < n; k++) begin
            sensor     = (k >= s_lo && k <= s_hi);
            ped_req    = (k == p0 || k == p1);
            flash_mode = (k >= f_lo && k <= f_hi);
            @(negedge clock);
        end
        sensor     = 1'b0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
    endtask

    initial begin
        // Idle: no demand keeps major green.
        start_test("idle");
        push(50, LG, LR, 1'b0);
        run(50, -1, -2, -1, -1, -1, -2);

        // Sensor held: minor green capped at max, then full major green again.
        start_test("sensor_held");
        push(8, LG, LR, 1'b0);
        push(3, LY, LR, 1'b0);
        push(2, LR, LR, 1'b0);
        push(10, LR, LG, 1'b0);
        push(3, LR, LY, 1'b0);
        push(2, LR, LR, 1'b0);
        push(8, LG, LR, 1'b0);
        push(3, LY, LR, 1'b0);
        run(39, 0, 1000, -1, -1, -1, -2);

        // Short sensor pulse: minor green gets only its minimum.
        start_test("sensor_pulse");
        push(11, LG, LR, 1'b0);
        push(3, LY, LR, 1'b0);
        push(2, LR, LR, 1'b0);
        push(4, LR, LG, 1'b0);
        push(3, LR, LY, 1'b0);
        push(2, LR, LR, 1'b0);
        push(5, LG, LR, 1'b0);
        run(30, 10, 11, -1, -1, -1, -2);

        // Pedestrian request; a second press during minor green is ignored.
        start_test("ped");
        push(8, LG, LR, 1'b0);
        push(3, LY, LR, 1'b0);
        push(2, LR, LR, 1'b0);
        push(4, LR, LG, 1'b1);
        push(3, LR, LY, 1'b0);
        push(2, LR, LR, 1'b0);
        push(18, LG, LR, 1'b0);
        run(40, -1, -2, 3, 14, -1, -2);

        // Flash entry via yellow and all-red, exit via all-red.
        start_test("flash");
        push(3, LG, LR, 1'b0);
        push(3, LY, LR, 1'b0);
        push(2, LR, LR, 1'b0);
        push(4, LY, LR, 1'b0);
        push(4, LO, LO, 1'b0);
        push(4, LY, LR, 1'b0);
        push(2, LO, LO, 1'b0);
        push(2, LR, LR, 1'b0);
        push(8, LG, LR, 1'b0);
        run(32, -1, -2, -1, -1, 2, 20);

        // Asynchronous reset in minor yellow.
        start_test("async_reset");
        push(8, LG, LR, 1'b0);
        push(3, LY, LR, 1'b0);
        push(2, LR, LR, 1'b0);
        push(10, LR, LG, 1'b0);
        push(2, LR, LY, 1'b0);
        run(24, 0, 1000, -1, -1, -1, -2);
        sensor = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (major !== LG || minor !== LR || ped_walk !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got major=%b minor=%b walk=%b, want 001 100 0",
                     major, minor, ped_walk);
        end
        sensor = 1'b0;
        repeat (3) @(negedge clock);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
